hazard_tracker: RTL and testbench
=================================

// Module: hazard_tracker
// PURPOSE
//  Destination-register shadow pipeline and load-use hazard detector for the 5-stage core.
//  Carries rs/rd/regwrite/memread from ID through EX, MEM and WB.
//  Produces ex_rs1/ex_rs2, mem_rd/mem_regwrite and wb_rd/wb_regwrite; the forwarding unit consumes these.
//  Asserts load-use stall, inserts EX bubbles, honours branch flush and global memory stall.
//  Keeps a saturating bubble counter for performance profiling.
// PARAMETERS
//  REG_AW  5   register-address width
//  CNT_W   32  width of bubble_count
// PORTS
//  clk           in   1       core clock, rising edge
//  reset_n       in   1       asynchronous, active-low reset
//  id_valid      in   1       ID holds a real instruction
//  id_rs1        in   REG_AW  ID source 1
//  id_rs2        in   REG_AW  ID source 2
//  id_uses_rs1   in   1       instruction reads rs1
//  id_uses_rs2   in   1       instruction reads rs2
//  id_rd         in   REG_AW  ID destination
//  id_regwrite   in   1       ID writes rd
//  id_memread    in   1       ID is a load
//  ex_flush      in   1       branch/jump redirect resolved in EX
//  mem_stall     in   1       D-cache miss; freeze whole pipe
//  ex_rs1        out  REG_AW  EX source 1 (to forwarding)
//  ex_rs2        out  REG_AW  EX source 2 (to forwarding)
//  mem_rd        out  REG_AW  MEM destination
//  mem_regwrite  out  1       MEM writes rd
//  wb_rd         out  REG_AW  WB destination
//  wb_regwrite   out  1       WB writes rd
//  lu_stall      out  1       hold PC and IF/ID this cycle (combinational)
//  bubble_count  out  CNT_W   load-use bubbles inserted, saturating
// BEHAVIOUR
//  - Reset (reset_n=0, async): every stage register and bubble_count cleared to 0; all outputs 0.
//  - Stage regs EX, MEM, WB: {valid, rs1, rs2, rd, regwrite, memread}. Advance one stage per clk edge.
//    A value on id_* appears on ex_* 1 cycle later, on mem_* 2 cycles later and on wb_* 3 cycles later.
//  - Bubble: stage content is all-zero (valid=0, rs1=rs2=rd=0, regwrite=memread=0).
//    Zeroing rs ensures the forwarding unit selects the register file.
//  - lu_stall = !mem_stall & !ex_flush & id_valid & ex.valid & ex.memread & ex.rd!=0 &
//    ((id_uses_rs1 & id_rs1==ex.rd) | (id_uses_rs2 & id_rs2==ex.rd)).
//  - Per-edge priority:
//    1. mem_stall=1: all stages hold; counter holds. ex_flush is ignored; the producer holds it until mem_stall falls.
//    2. ex_flush=1: EX <- bubble; MEM <- EX; WB <- MEM. The branch in EX itself completes.
//    3. lu_stall=1: EX <- bubble; MEM <- EX; WB <- MEM; bubble_count += 1, saturating at all-ones.
//    4. Otherwise: EX <- id_* if id_valid, else bubble; MEM <- EX; WB <- MEM.
//  - mem_regwrite/wb_regwrite are the stage regwrite ANDed with valid.
//    rd=0 is passed through unchanged; the forwarding unit masks x0.
//  - A load followed by a dependent instruction gives exactly one bubble.
//    The next cycle the load is in MEM and the value is forwarded from WB later.
//  - A load with an independent next instruction gives no stall.
//  - Reset asserted mid-stall: stall clears immediately (async); the pipe restarts empty.
// STRUCTURE
//  - Shared package pipeline_pkg:
//    REG_AW; forwarding-select constants FWD_MEM=2'b00, FWD_WB=2'b01, FWD_RF=2'b10;
//    stage-record field layout.
//  - Sub-module pipe_dst_stage: one stage register with load/hold/bubble controls and async reset.
//    Instantiated 3x (EX, MEM, WB). Hazard logic and counter stay in the top.
// TESTING
//  1. Reset: pulse reset_n low mid-traffic -> all outputs 0 at once; bubble_count=0.
//  2. Load-use: lw x5 (memread, rd=5), then add rs1=5 -> lu_stall=1 for one cycle; ex_rs1=0 next cycle;
//     mem_rd=5 one cycle after lu_stall; add reaches EX one cycle later; bubble_count=1.
//  3. No hazard: lw x5, then add rs1=6 rs2=7 -> lu_stall stays 0; wb_rd=5 three cycles after issue.
//  4. Flush vs stall: ex_flush=1 in the same cycle a load-use match exists -> lu_stall=0;
//     EX bubbled; bubble_count unchanged.
//  5. mem_stall: hold 3 cycles with rd=9 in MEM -> mem_rd=9 and wb_rd unchanged throughout;
//     advance on release.
//  6. Saturation: CNT_W=4, 20 load-use events -> bubble_count=15; x0 load with rs1=0 use -> no stall.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-address width, forwarding-select
// encodings and the destination-shadow stage record layout.
package pipeline_pkg;

   localparam int unsigned REG_AW = 5;

   // Forwarding-unit operand select encodings
   localparam logic [1:0] FWD_MEM = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_RF  = 2'b10;

   // One stage of the destination-register shadow pipeline
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } stage_t;

   // All-zero record; zero rs fields steer forwarding to the register file
   localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/pipe_dst_stage.sv
// One shadow-pipeline stage register with hold and bubble controls.
//  clk, reset_n : clock, async active-low reset
//  hold_i       : keep current content (global memory stall)
//  bubble_i     : load an all-zero record instead of d_i
//  d_i          : record from the previous stage
//  q_o          : registered stage record
module pipe_dst_stage
   import pipeline_pkg::*;
(
   input  logic   clk,
   input  logic   reset_n,
   input  logic   hold_i,
   input  logic   bubble_i,
   input  stage_t d_i,
   output stage_t q_o
);

   stage_t stage_q;
   stage_t stage_d;

   // Hold dominates bubble
   always_comb begin
      stage_d = stage_q;
      if (!hold_i) begin
         stage_d = bubble_i ? STAGE_BUBBLE : d_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage_q <= STAGE_BUBBLE;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q;

endmodule

// File: rtl/hazard_tracker.sv
// Destination-register shadow pipeline (EX/MEM/WB) and load-use hazard
// detector feeding the forwarding unit, with a saturating bubble counter.
//  clk, reset_n          : clock, async active-low reset
//  id_*                  : instruction currently in ID
//  ex_flush              : branch/jump redirect resolved in EX
//  mem_stall             : D-cache miss, freeze the whole pipe
//  ex_rs1/ex_rs2         : EX source registers
//  mem_rd/mem_regwrite   : MEM destination and write enable
//  wb_rd/wb_regwrite     : WB destination and write enable
//  lu_stall              : combinational load-use stall (hold PC and IF/ID)
//  bubble_count          : load-use bubbles inserted, saturating
module hazard_tracker
   import pipeline_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs1,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              ex_flush,
   input  logic              mem_stall,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] mem_rd,
   output logic              mem_regwrite,
   output logic [REG_AW-1:0] wb_rd,
   output logic              wb_regwrite,
   output logic              lu_stall,
   output logic [CNT_W-1:0]  bubble_count
);

   stage_t id_rec;
   stage_t ex_st;
   stage_t mem_st;
   stage_t wb_st;
   logic   ex_bubble;
   logic   rs_match;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Pack the ID instruction into a stage record
   always_comb begin
      id_rec          = STAGE_BUBBLE;
      id_rec.valid    = 1'b1;
      id_rec.rs1      = id_rs1;
      id_rec.rs2      = id_rs2;
      id_rec.rd       = id_rd;
      id_rec.regwrite = id_regwrite;
      id_rec.memread  = id_memread;
   end

   // Load in EX whose destination is read by the instruction in ID
   assign rs_match = (id_uses_rs1 && (id_rs1 == ex_st.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_st.rd));

   assign lu_stall = !mem_stall && !ex_flush && id_valid && ex_st.valid &&
                     ex_st.memread && (ex_st.rd != '0) && rs_match;

   // Flush and load-use both replace the ID instruction with a bubble
   assign ex_bubble = ex_flush || lu_stall || !id_valid;

   pipe_dst_stage u_ex (
      .clk      (clk),
      .reset_n  (reset_n),
      .hold_i   (mem_stall),
      .bubble_i (ex_bubble),
      .d_i      (id_rec),
      .q_o      (ex_st)
   );

   pipe_dst_stage u_mem (
      .clk      (clk),
      .reset_n  (reset_n),
      .hold_i   (mem_stall),
      .bubble_i (1'b0),
      .d_i      (ex_st),
      .q_o      (mem_st)
   );

   pipe_dst_stage u_wb (
      .clk      (clk),
      .reset_n  (reset_n),
      .hold_i   (mem_stall),
      .bubble_i (1'b0),
      .d_i      (mem_st),
      .q_o      (wb_st)
   );

   // Saturating bubble counter; lu_stall is already low under mem_stall
   always_comb begin
      cnt_d = cnt_q;
      if (lu_stall && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ex_rs1       = ex_st.rs1;
   assign ex_rs2       = ex_st.rs2;
   assign mem_rd       = mem_st.rd;
   assign mem_regwrite = mem_st.regwrite && mem_st.valid;
   assign wb_rd        = wb_st.rd;
   assign wb_regwrite  = wb_st.regwrite && wb_st.valid;
   assign bubble_count = cnt_q;

endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized and directed bench for hazard_tracker against a list-of-stages
// reference model; a second instance with a 4-bit counter covers saturation.
module tb_hazard_tracker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       ex_flush, mem_stall;

   logic [4:0]  ex_rs1, ex_rs2, mem_rd, wb_rd;
   logic        mem_regwrite, wb_regwrite, lu_stall;
   logic [31:0] bubble_count;

   logic [4:0]  s_ex_rs1, s_ex_rs2, s_mem_rd, s_wb_rd;
   logic        s_mem_regwrite, s_wb_regwrite, s_lu_stall;
   logic [3:0]  s_bubble_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_tracker dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
      .mem_stall(mem_stall), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd),
      .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .lu_stall(lu_stall), .bubble_count(bubble_count)
   );

   hazard_tracker #(.CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
      .mem_stall(mem_stall), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .mem_rd(s_mem_rd),
      .mem_regwrite(s_mem_regwrite), .wb_rd(s_wb_rd), .wb_regwrite(s_wb_regwrite),
      .lu_stall(s_lu_stall), .bubble_count(s_bubble_count)
   );

   // Reference model: in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB
   typedef struct {
      bit       v;
      bit [4:0] rs1, rs2, rd;
      bit       rw, mr;
   } rec_t;

   rec_t        pipe [3];
   bit   [31:0] m_cnt;
   bit   [3:0]  m_cnt4;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
      m_cnt  = 0;
      m_cnt4 = 0;
   endtask

   function automatic bit model_stall();
      bit dep;
      dep = (id_uses_rs1 && id_rs1 == pipe[0].rd) || (id_uses_rs2 && id_rs2 == pipe[0].rd);
      return !mem_stall && !ex_flush && id_valid && pipe[0].v && pipe[0].mr &&
             pipe[0].rd != 0 && dep;
   endfunction

   // Advance the model by one clock edge given the stall decided before it
   task automatic model_edge(input bit stall);
      rec_t nrec;
      if (mem_stall) return;
      nrec = '{default: 0};
      if (id_valid && !ex_flush && !stall)
         nrec = '{v: 1'b1, rs1: id_rs1, rs2: id_rs2, rd: id_rd, rw: id_regwrite, mr: id_memread};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nrec;
      if (stall) begin
         if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
         if (m_cnt4 != 4'd15) m_cnt4++;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("ex_rs1",        32'(ex_rs1),       32'(pipe[0].rs1));
      check("ex_rs2",        32'(ex_rs2),       32'(pipe[0].rs2));
      check("mem_rd",        32'(mem_rd),       32'(pipe[1].rd));
      check("mem_regwrite",  32'(mem_regwrite), 32'(pipe[1].v && pipe[1].rw));
      check("wb_rd",         32'(wb_rd),        32'(pipe[2].rd));
      check("wb_regwrite",   32'(wb_regwrite),  32'(pipe[2].v && pipe[2].rw));
      check("lu_stall",      32'(lu_stall),     32'(model_stall()));
      check("bubble_count",  bubble_count,      m_cnt);
      check("lu_stall_c4",   32'(s_lu_stall),   32'(model_stall()));
      check("bubble_cnt_c4", 32'(s_bubble_count), 32'(m_cnt4));
   endtask

   // Called at a falling edge with inputs already applied
   task automatic step();
      bit s;
      #1;
      check_all();
      s = model_stall();
      @(posedge clk);
      model_edge(s);
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u1, input bit u2, input bit [4:0] rd,
                        input bit rw, input bit mr, input bit fl, input bit ms);
      id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      id_rd = rd;    id_regwrite = rw; id_memread = mr; ex_flush = fl; mem_stall = ms;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse between clock edges
   task automatic reset_pulse();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      id_rd = 0; id_regwrite = 0; id_memread = 0; ex_flush = 0; mem_stall = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset_n = 1'b1;

      // Load-use: lw x5 then add x7 <- x5
      drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0);
      drive(1, 5, 6, 1, 1, 7, 1, 0, 0, 0);
      check("lu_bubble_ex_rs1", 32'(ex_rs1), 32'd0);
      check("lu_mem_rd", 32'(mem_rd), 32'd5);
      check("lu_count", bubble_count, 32'd1);
      drive(1, 5, 6, 1, 1, 7, 1, 0, 0, 0);
      check("lu_add_in_ex", 32'(ex_rs1), 32'd5);
      idle(3);

      // Independent use after a load
      drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0);
      drive(1, 6, 7, 1, 1, 8, 1, 0, 0, 0);
      idle(1);
      check("nohaz_wb_rd", 32'(wb_rd), 32'd5);
      idle(2);

      // Flush wins over a load-use match
      drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0);
      drive(1, 5, 6, 1, 1, 7, 1, 0, 1, 0);
      check("flush_ex_bubble", 32'(ex_rs1), 32'd0);
      idle(3);

      // Memory stall holding rd=9 in MEM
      drive(1, 3, 4, 1, 1, 9, 1, 0, 0, 0);
      drive(1, 1, 1, 1, 0, 10, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 2, 2, 1, 0, 11, 1, 0, 1, 1);
         check("mstall_mem_rd", 32'(mem_rd), 32'd9);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("mstall_release_wb", 32'(wb_rd), 32'd9);
      idle(3);

      // x0 load followed by an x0 use never stalls
      drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      drive(1, 0, 0, 1, 1, 3, 1, 0, 0, 0);
      idle(3);

      // Saturation: 20 load-use events from a clean counter
      reset_pulse();
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 2, 1, 0, 5, 1, 1, 0, 0);
         drive(1, 5, 6, 1, 1, 7, 1, 0, 0, 0);
         drive(1, 5, 6, 1, 1, 7, 1, 0, 0, 0);
      end
      check("sat_count4", 32'(s_bubble_count), 32'd15);
      check("sat_count32", bubble_count, 32'd20);

      // Random traffic on a small register window to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) reset_pulse();
         drive($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
               5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
